// File: rtl/orb_wr_arbiter.sv
// Two-channel orbit-word write arbiter: captures level-style write enables as edges,
// round-robins the held words into a double-banked RAM and swaps bank every FRAME_WORDS grants.
module orb_wr_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 12,
  parameter int FRAME_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we1_i,
  input  logic              we2_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              en,
  input  logic              clr,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              bank_sw,
  output logic              frame_done,
  output logic              ovf1,
  output logic              ovf2
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(FRAME_WORDS - 1);

  logic [1:0]        we_in;
  logic [ADDR_W-1:0] addr_in [2];
  logic [DATA_W-1:0] data_in [2];

  logic [1:0]        we_prev_q;
  logic [1:0]        edge_det;
  logic [1:0]        gnt;
  logic [1:0]        valid_q,     valid_d;
  logic [1:0]        ovf_q,       ovf_d;
  logic [ADDR_W-1:0] addr_hold_q [2];
  logic [ADDR_W-1:0] addr_hold_d [2];
  logic [DATA_W-1:0] data_hold_q [2];
  logic [DATA_W-1:0] data_hold_d [2];
  logic              last_ch1_q,  last_ch1_d;
  logic [ADDR_W:0]   cnt_q,       cnt_d;
  logic              bank_q,      bank_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W:0]   ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_data_q,  ram_data_d;
  logic              frame_done_q, frame_done_d;

  assign we_in      = {we2_i, we1_i};
  assign addr_in[0] = addr1_i;
  assign addr_in[1] = addr2_i;
  assign data_in[0] = data1_i;
  assign data_in[1] = data2_i;

  always_comb begin
    edge_det     = we_in & ~we_prev_q;
    gnt          = '0;
    valid_d      = valid_q;
    ovf_d        = '0;
    addr_hold_d  = addr_hold_q;
    data_hold_d  = data_hold_q;
    last_ch1_d   = last_ch1_q;
    cnt_d        = cnt_q;
    bank_d       = bank_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    frame_done_d = 1'b0;

    if (en && !clr) begin
      if (valid_q[0] && (!valid_q[1] || !last_ch1_q)) gnt[0] = 1'b1;
      else if (valid_q[1])                           gnt[1] = 1'b1;
    end

    for (int i = 0; i < 2; i++) begin
      if (gnt[i]) valid_d[i] = 1'b0;
      // A fresh edge always wins over the grant-clear; ovf only if the old word was never taken.
      if (edge_det[i]) begin
        valid_d[i]     = 1'b1;
        addr_hold_d[i] = addr_in[i];
        data_hold_d[i] = data_in[i];
        ovf_d[i]       = valid_q[i] & ~gnt[i];
      end
    end

    if (gnt != 2'b00) begin
      ram_we_d   = 1'b1;
      ram_addr_d = {bank_q, gnt[1] ? addr_hold_q[1] : addr_hold_q[0]};
      ram_data_d = gnt[1] ? data_hold_q[1] : data_hold_q[0];
      // Pointer only moves on contention, so alternation is between competing requests.
      if (valid_q == 2'b11) last_ch1_d = gnt[0];
      if (cnt_q == LAST_CNT) begin
        cnt_d        = '0;
        bank_d       = ~bank_q;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (clr) begin
      valid_d      = '0;
      ovf_d        = '0;
      cnt_d        = '0;
      bank_d       = 1'b0;
      last_ch1_d   = 1'b0;
      ram_we_d     = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_prev_q    <= '0;
      valid_q      <= '0;
      ovf_q        <= '0;
      addr_hold_q  <= '{default: '0};
      data_hold_q  <= '{default: '0};
      last_ch1_q   <= 1'b0;
      cnt_q        <= '0;
      bank_q       <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      we_prev_q    <= we_in;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      addr_hold_q  <= addr_hold_d;
      data_hold_q  <= data_hold_d;
      last_ch1_q   <= last_ch1_d;
      cnt_q        <= cnt_d;
      bank_q       <= bank_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign bank_sw    = bank_q;
  assign frame_done = frame_done_q;
  assign ovf1       = ovf_q[0];
  assign ovf2       = ovf_q[1];

endmodule
